// File: rtl/fetch_redirect_unit.sv
// ============================================================================
// Module      : fetch_redirect_unit
// Description : Program counter and instruction fetch sequencer. Issues
//               req/ack fetches to instruction memory, presents one registered
//               instruction to decode, and redirects on branch/jump, discarding
//               any wrong-path fetch still in flight.
// Config      : FETCH_MISALIGN_CHECK_EN - misaligned redirect targets raise a
//               sticky misalign_err_o and park the unit in ERROR until rst.
//               Undefined: target[1:0] is forced to 2'b00.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_redirect_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        misalign_err_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1
`ifdef FETCH_MISALIGN_CHECK_EN
    , S_ERROR = 2'd2
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] kill_addr_q, kill_addr_d;   // address of the fetch being discarded
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;

  // Redirect request; jump has priority over branch.
  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;
  assign redirect   = jump_i | branch_taken_i;
  assign target_raw = jump_i ? jump_target_i : branch_target_i;
  assign target     = target_raw & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  logic misaligned;
  assign misaligned = |target_raw[1:0];
`endif

  // Next-state logic: sequencing of fetch, hand-off to decode and redirects.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    kill_addr_d = kill_addr_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_d  = misalign_q;
`endif
    case (state_q)
      S_FETCH: begin
`ifdef FETCH_MISALIGN_CHECK_EN
        if (redirect && misaligned) begin
          state_d    = S_ERROR;
          misalign_d = 1'b1;
          kill_d     = 1'b0;
        end else
`endif
        if (redirect) begin
          // Any returning data belongs to the old path and is dropped.
          pc_d = target;
          if (imem_ack_i) begin
            kill_d = 1'b0;
          end else begin
            // Keep the outstanding request's address stable until it is acked.
            kill_d = 1'b1;
            if (!kill_q) begin
              kill_addr_d = pc_q;
            end
          end
        end else if (imem_ack_i) begin
          if (kill_q) begin
            kill_d = 1'b0;
          end else begin
            instr_d    = imem_rdata_i;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
            state_d    = S_VALID;
          end
        end
      end
      S_VALID: begin
`ifdef FETCH_MISALIGN_CHECK_EN
        if (redirect && misaligned) begin
          state_d    = S_ERROR;
          misalign_d = 1'b1;
        end else
`endif
        if (redirect) begin
          pc_d    = target;
          state_d = S_FETCH;
        end else if (!stall_i) begin
          state_d = S_FETCH;
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      S_ERROR: begin
        state_d = S_ERROR;
      end
`endif
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_VECTOR;
      kill_q      <= 1'b0;
      kill_addr_q <= RESET_VECTOR;
      instr_q     <= NOP_INSTR;
      instr_pc_q  <= 32'h0000_0000;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      kill_addr_q <= kill_addr_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  // Request is suppressed while rst is held so it first rises after release.
  assign imem_req_o    = (state_q == S_FETCH) && !rst;
  assign imem_addr_o   = kill_q ? kill_addr_q : pc_q;
  assign instr_valid_o = (state_q == S_VALID);
  assign instr_o       = instr_valid_o ? instr_q : NOP_INSTR;
  assign instr_pc_o    = instr_pc_q;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign_err_o = misalign_q;
`else
  assign misalign_err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_redirect_unit.sv
// ============================================================================
// Module      : tb_fetch_redirect_unit
// Description : Scoreboard bench for fetch_redirect_unit. Directed scenarios
//               push expected fetch addresses and delivered instructions into
//               queues; a monitor pops and compares on every imem handshake and
//               every new instr_valid. Honours FETCH_MISALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_redirect_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign_err;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  fetch_redirect_unit dut (
    .clk             (clk),
    .rst             (rst),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .stall_i         (stall),
    .imem_req_o      (imem_req),
    .imem_addr_o     (imem_addr),
    .imem_ack_i      (imem_ack),
    .imem_rdata_i    (imem_rdata),
    .instr_valid_o   (instr_valid),
    .instr_o         (instr),
    .instr_pc_o      (instr_pc),
    .misalign_err_o  (misalign_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_data_q[$];

  bit resp_en = 1'b0;
  int lat = 0;
  int cnt = 0;
  logic prev_valid = 1'b0;

  // Instruction memory contents seen by the bench.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0008) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 ^ a;
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting, got none expected event", name);
  endfunction

  task automatic push_deliver(input logic [31:0] a);
    exp_addr_q.push_back(a);
    exp_pc_q.push_back(a);
    exp_data_q.push_back(mem_word(a));
  endtask

  task automatic push_fetch_only(input logic [31:0] a);
    exp_addr_q.push_back(a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input logic [31:0] pc);
    int n = 0;
    while (!(instr_valid && instr_pc == pc) && n < 80) begin
      tick();
      n++;
    end
    if (n >= 80) timeout("wait_valid");
  endtask

  task automatic wait_req(input logic [31:0] a);
    int n = 0;
    while (!(imem_req && imem_addr == a) && n < 80) begin
      tick();
      n++;
    end
    if (n >= 80) timeout("wait_req");
  endtask

  // Hold rst for two cycles (optionally with a redirect that must be ignored).
  task automatic do_reset(input bit with_redirect);
    rst = 1'b1;
    resp_en = 1'b0;
    stall = 1'b0;
    jump = 1'b0;
    branch_taken = with_redirect;
    branch_target = 32'h0000_0300;
    tick();
    tick();
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_misalign_err", 32'(misalign_err), 32'd0);
  endtask

  // Memory responder: acks after 'lat' request cycles (0 = same cycle).
  always begin
    @(posedge clk);
    #3;
    if (rst || !imem_req || imem_ack) cnt = 0;
    if (resp_en && !rst && imem_req) begin
      if (cnt >= lat) begin
        imem_ack = 1'b1;
        imem_rdata = mem_word(imem_addr);
      end else begin
        imem_ack = 1'b0;
        cnt++;
      end
    end else begin
      imem_ack = 1'b0;
    end
  end

  // Monitor: compare every handshake and every newly valid instruction.
  always @(negedge clk) begin
    if (imem_req && imem_ack) begin
      if (exp_addr_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL fetch_unexpected: got addr %h expected no fetch", imem_addr);
      end else begin
        check("fetch_addr", imem_addr, exp_addr_q.pop_front());
      end
    end
    if (instr_valid && !prev_valid) begin
      if (exp_pc_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL instr_unexpected: got pc %h data %h expected none", instr_pc, instr);
      end else begin
        check("instr_pc", instr_pc, exp_pc_q.pop_front());
        check("instr_data", instr, exp_data_q.pop_front());
      end
    end
    prev_valid = instr_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();

    // 1: 1-cycle ack latency, sequential fetch 0,4,8.
    do_reset(1'b0);
    lat = 1;
    resp_en = 1'b1;
    push_deliver(32'h0);
    push_deliver(32'h4);
    push_deliver(32'h8);
    rst = 1'b0;
    #1;
    check("req_after_rst", 32'(imem_req), 32'd1);
    check("addr_after_rst", imem_addr, 32'h0);
    wait_valid(32'h8);
    resp_en = 1'b0;

    // 2: same-cycle ack, stall held 3 cycles in VALID.
    do_reset(1'b0);
    lat = 0;
    stall = 1'b1;
    resp_en = 1'b1;
    push_deliver(32'h0);
    rst = 1'b0;
    wait_valid(32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_instr", instr, mem_word(32'h0));
      check("stall_instr_pc", instr_pc, 32'h0);
      check("stall_req", 32'(imem_req), 32'd0);
      check("stall_valid", 32'(instr_valid), 32'd1);
    end
    push_deliver(32'h4);
    stall = 1'b0;
    wait_valid(32'h4);
    resp_en = 1'b0;

    // 3: branch taken in VALID at 0x10 to 0x40.
    do_reset(1'b0);
    lat = 0;
    resp_en = 1'b1;
    for (int a = 0; a <= 16; a += 4) push_deliver(32'(a));
    rst = 1'b0;
    wait_valid(32'h10);
    branch_taken = 1'b1;
    branch_target = 32'h40;
    push_deliver(32'h40);
    tick();
    branch_taken = 1'b0;
    check("br_valid_drop", 32'(instr_valid), 32'd0);
    check("br_req", 32'(imem_req), 32'd1);
    check("br_addr", imem_addr, 32'h40);
    wait_valid(32'h40);
    resp_en = 1'b0;

    // 4: redirect to 0x80 while awaiting ack at 0x8; its data must be dropped.
    do_reset(1'b0);
    lat = 3;
    resp_en = 1'b1;
    push_deliver(32'h0);
    push_deliver(32'h4);
    push_fetch_only(32'h8);
    push_deliver(32'h80);
    rst = 1'b0;
    wait_req(32'h8);
    branch_taken = 1'b1;
    branch_target = 32'h80;
    tick();
    branch_taken = 1'b0;
    check("kill_addr_held", imem_addr, 32'h8);
    check("kill_req_held", 32'(imem_req), 32'd1);
    wait_valid(32'h80);
    resp_en = 1'b0;

    // 5: redirect during rst ignored; jump beats branch.
    do_reset(1'b1);
    lat = 0;
    resp_en = 1'b1;
    push_deliver(32'h0);
    push_deliver(32'h100);
    branch_taken = 1'b0;
    rst = 1'b0;
    wait_valid(32'h0);
    jump = 1'b1;
    jump_target = 32'h100;
    branch_taken = 1'b1;
    branch_target = 32'h200;
    tick();
    jump = 1'b0;
    branch_taken = 1'b0;
    check("jump_prio_addr", imem_addr, 32'h100);
    wait_valid(32'h100);
    resp_en = 1'b0;

    // 6: misaligned redirect target 0x42.
    do_reset(1'b0);
    lat = 0;
    resp_en = 1'b1;
    push_deliver(32'h0);
    rst = 1'b0;
    wait_valid(32'h0);
    branch_taken = 1'b1;
    branch_target = 32'h42;
`ifdef FETCH_MISALIGN_CHECK_EN
    tick();
    branch_taken = 1'b0;
    check("mis_err", 32'(misalign_err), 32'd1);
    check("mis_req", 32'(imem_req), 32'd0);
    check("mis_valid", 32'(instr_valid), 32'd0);
    jump = 1'b1;
    jump_target = 32'h100;
    tick();
    jump = 1'b0;
    tick();
    tick();
    check("mis_err_sticky", 32'(misalign_err), 32'd1);
    check("mis_req_parked", 32'(imem_req), 32'd0);
`else
    push_deliver(32'h40);
    tick();
    branch_taken = 1'b0;
    check("mis_aligned_addr", imem_addr, 32'h40);
    check("mis_err_tied", 32'(misalign_err), 32'd0);
    wait_valid(32'h40);
`endif
    resp_en = 1'b0;

    // 7: pc wraps from 0xFFFF_FFFC to 0.
    do_reset(1'b0);
    lat = 0;
    resp_en = 1'b1;
    push_deliver(32'h0);
    push_deliver(32'hFFFF_FFFC);
    push_deliver(32'h0);
    rst = 1'b0;
    wait_valid(32'h0);
    jump = 1'b1;
    jump_target = 32'hFFFF_FFFC;
    tick();
    jump = 1'b0;
    wait_valid(32'hFFFF_FFFC);
    wait_valid(32'h0);
    resp_en = 1'b0;

    do_reset(1'b0);
    tick();
    check("fetch_queue_empty", 32'(exp_addr_q.size()), 32'd0);
    check("instr_queue_empty", 32'(exp_pc_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
